data_mem_ctrl: RTL and testbench

Parametrised, clocked, byte-addressable big-endian data memory for the SPARC datapath. It serves load, store, SWAP and LDSTUB requests of byte, halfword or word size through a Req/Done handshake with a configurable number of wait states. It enforces natural alignment with a trap output and performs SWAP/LDSTUB atomically in a single access cycle. It sits between the MEM-stage control and the register-file writeback path.

---
 rtl/data_mem_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Byte-addressable, big-endian data memory with a Req/Done handshake and a
// configurable number of wait states. Serves load, store, SWAP and LDSTUB
// requests of byte, halfword or word size. Misaligned or malformed requests
// are rejected with a one-cycle Done+Trap pulse. SWAP and LDSTUB are atomic:
// the old value is read and the new value written on the same access edge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          request, sampled only while idle
//   op           00 load, 01 store, 10 SWAP, 11 LDSTUB
//   size         00 byte, 01 halfword, 10 word, 11 reserved
//   sign_extend  sign-extend byte/halfword loads
//   address      byte address
//   data_in      store/swap data, right-justified
//   busy         high whenever an accepted request is in flight
//   done         one-cycle completion pulse
//   trap         one-cycle pulse together with done on a rejected request
//   data_out     load result, held until the next load/SWAP/LDSTUB completes
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [1:0]            op,
    input  logic [1:0]            size,
    input  logic                  sign_extend,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  trap,
    output logic [31:0]           data_out
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_SWAP   = 2'b10;
    localparam logic [1:0] OP_LDSTUB = 2'b11;
    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;

    // Memory is split into four byte lanes; lane k holds every byte whose
    // address has [1:0]==k. Lane 0 is the most significant byte of a word.
    localparam int ROW_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
    localparam int ROWS  = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic [1:0]              op_reg;
    logic [1:0]              size_reg;
    logic                    se_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             din_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    trap_reg;
    logic [31:0]             dout_reg;

    logic                    illegal;
    logic [ROW_W-1:0]        rd_row;
    logic [ROW_W-1:0]        wr_row;
    logic [3:0]              lane_we;
    logic [31:0]             lane_wdata;
    logic [31:0]             rd_word;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [31:0]             load_val;

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign trap     = trap_reg;
    assign data_out = dout_reg;

    always_comb begin
        illegal = 1'b0;
        if (size == 2'b11)                           illegal = 1'b1;
        if (size == SZ_HALF && address[0])           illegal = 1'b1;
        if (size == SZ_WORD && address[1:0] != 2'b0) illegal = 1'b1;
        if (op == OP_SWAP && size != SZ_WORD)        illegal = 1'b1;
        if (op == OP_LDSTUB && size != SZ_BYTE)      illegal = 1'b1;
    end

    // While idle the read port follows the incoming address so the old data
    // is already registered when the access cycle begins, even with zero
    // wait states. Nothing writes between acceptance and the access edge.
    generate
        if (ADDR_WIDTH > 2) begin : g_rows
            assign rd_row = (state_reg == ST_IDLE) ? address[ADDR_WIDTH-1:2]
                                                   : addr_reg[ADDR_WIDTH-1:2];
            assign wr_row = addr_reg[ADDR_WIDTH-1:2];
        end else begin : g_rows_single
            assign rd_row = '0;
            assign wr_row = '0;
        end
    endgenerate

    // Lane write enables/data for the access edge.
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = 32'h0;
        if (state_reg == ST_ACCESS) begin
            case (op_reg)
                OP_STORE, OP_SWAP: begin
                    case (size_reg)
                        SZ_WORD: begin
                            lane_we    = 4'b1111;
                            lane_wdata = din_reg;
                        end
                        SZ_HALF: begin
                            lane_we    = addr_reg[1] ? 4'b1100 : 4'b0011;
                            lane_wdata = {2{din_reg[15:0]}};
                        end
                        default: begin
                            lane_we    = 4'b0001 << addr_reg[1:0];
                            lane_wdata = {4{din_reg[7:0]}};
                        end
                    endcase
                end
                OP_LDSTUB: begin
                    lane_we    = 4'b0001 << addr_reg[1:0];
                    lane_wdata = {4{8'hFF}};
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:ROWS-1];
            logic [7:0] rdata_reg;

            // Read-before-write: the registered read returns the old byte.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[wr_row] <= lane_wdata[31-8*gi -: 8];
                end
                rdata_reg <= mem[rd_row];
            end

            assign rd_word[31-8*gi -: 8] = rdata_reg;
        end
    endgenerate

    always_comb begin
        case (addr_reg[1:0])
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = addr_reg[1] ? rd_word[15:0] : rd_word[31:16];
        case (size_reg)
            SZ_BYTE: load_val = {{24{se_reg & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{16{se_reg & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
        // LDSTUB always zero-extends.
        if (op_reg == OP_LDSTUB) begin
            load_val = {24'h0, rd_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            op_reg    <= OP_LOAD;
            size_reg  <= SZ_BYTE;
            se_reg    <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= 32'h0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            trap_reg  <= 1'b0;
            dout_reg  <= 32'h0;
        end else begin
            done_reg <= 1'b0;
            trap_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        op_reg   <= op;
                        size_reg <= size;
                        se_reg   <= sign_extend;
                        addr_reg <= address;
                        din_reg  <= data_in;
                        if (illegal) begin
                            done_reg <= 1'b1;
                            trap_reg <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state_reg <= ST_ACCESS;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= 4'(WAIT_STATES);
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg <= 4'd1) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= ST_ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    if (op_reg != OP_STORE) begin
                        dout_reg <= load_val;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: two instances (2 and 0 wait states) driven by
// directed and random requests, checked against a byte-array memory model.
module tb_data_mem_ctrl;

    localparam int AW = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic [1:0]  op [2];
    logic [1:0]  size [2];
    logic        se [2];
    logic [AW-1:0] addr [2];
    logic [31:0] din [2];
    logic        busy [2];
    logic        done [2];
    logic        trap [2];
    logic [31:0] dout [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .op(op[0]), .size(size[0]),
        .sign_extend(se[0]), .address(addr[0]), .data_in(din[0]),
        .busy(busy[0]), .done(done[0]), .trap(trap[0]), .data_out(dout[0])
    );

    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .op(op[1]), .size(size[1]),
        .sign_extend(se[1]), .address(addr[1]), .data_in(din[1]),
        .busy(busy[1]), .done(done[1]), .trap(trap[1]), .data_out(dout[1])
    );

    // Reference model
    logic [7:0]  mem_m [2][512];
    logic [31:0] exp_dout [2];
    int          exp_lat;
    logic        exp_trap;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic bit is_legal(input logic [1:0] o, input logic [1:0] s, input logic [8:0] a);
        if (s == 2'd3) return 1'b0;
        if (s == 2'd1 && a[0]) return 1'b0;
        if (s == 2'd2 && a[1:0] != 2'd0) return 1'b0;
        if (o == 2'd2 && s != 2'd2) return 1'b0;
        if (o == 2'd3 && s != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_op(input int d, input logic [1:0] o, input logic [1:0] s,
                            input logic e, input logic [8:0] a, input logic [31:0] dn);
        int n;
        logic [31:0] v;
        if (!is_legal(o, s, a)) begin
            exp_trap = 1'b1;
            exp_lat  = 0;
            return;
        end
        exp_trap = 1'b0;
        exp_lat  = ws_of(d) + 1;
        n = 1 << s;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mem_m[d][int'(a) + i]};
        case (o)
            2'd0: begin
                if (e && n == 1 && v[7])  v = v | 32'hFFFFFF00;
                if (e && n == 2 && v[15]) v = v | 32'hFFFF0000;
                exp_dout[d] = v;
            end
            2'd1, 2'd2: begin
                if (o == 2'd2) exp_dout[d] = v;
                for (int i = 0; i < n; i++)
                    mem_m[d][int'(a) + i] = 8'(dn >> (8 * (n - 1 - i)));
            end
            default: begin
                exp_dout[d] = v;
                mem_m[d][a] = 8'hFF;
            end
        endcase
    endtask

    // Called at a negedge; returns just after the accepting edge with
    // the inputs scrambled to show they were latched.
    task automatic issue(input int d, input logic [1:0] o, input logic [1:0] s,
                         input logic e, input logic [8:0] a, input logic [31:0] dn);
        op[d] = o; size[d] = s; se[d] = e; addr[d] = a; din[d] = dn; req[d] = 1'b1;
        model_op(d, o, s, e, a, dn);
        @(posedge clk);
        #1;
        req[d]  = 1'b0;
        op[d]   = 2'($urandom);
        size[d] = 2'($urandom);
        se[d]   = 1'($urandom);
        addr[d] = AW'($urandom);
        din[d]  = $urandom;
    endtask

    // Waits for done (bounded) and checks latency, trap, busy and data_out.
    // Returns at the negedge of the done cycle.
    task automatic finish_op(input int d, input string tag, input bit poke);
        int k = 0;
        bit got_done = 1'b0;
        bit busy_ok = 1'b1;
        @(negedge clk);
        while (1) begin
            if (done[d]) begin
                got_done = 1'b1;
                break;
            end
            if (!busy[d]) busy_ok = 1'b0;
            if (poke && k == 0) begin
                req[d] = 1'b1; op[d] = 2'd1; size[d] = 2'd2; addr[d] = '0; din[d] = $urandom;
            end
            if (poke && k == 1) req[d] = 1'b0;
            if (k >= 40) break;
            @(negedge clk);
            k++;
        end
        check_val({tag, "_done"}, 32'(got_done), 32'd1);
        check_val({tag, "_lat"}, k, exp_lat);
        check_val({tag, "_trap"}, 32'(trap[d]), 32'(exp_trap));
        check_val({tag, "_busy"}, {30'h0, busy_ok, busy[d]}, 32'h2);
        check_val({tag, "_dout"}, dout[d], exp_dout[d]);
        $display("txn d=%0d %s lat=%0d trap=%0b dout=%h", d, tag, k, trap[d], dout[d]);
    endtask

    task automatic do_op(input int d, input string tag, input logic [1:0] o, input logic [1:0] s,
                         input logic e, input logic [8:0] a, input logic [31:0] dn);
        @(negedge clk);
        issue(d, o, s, e, a, dn);
        finish_op(d, tag, 1'b0);
    endtask

    initial begin
        bit extra;
        logic [1:0] ro, rs;
        logic [8:0] ra;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; op[d] = '0; size[d] = '0; se[d] = 1'b0; addr[d] = '0; din[d] = '0;
            exp_dout[d] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_busy", 32'(busy[d]), 32'd0);
            check_val("rst_done", 32'(done[d]), 32'd0);
            check_val("rst_trap", 32'(trap[d]), 32'd0);
            check_val("rst_dout", dout[d], 32'h0);
        end

        // Fill the region used by the tests with known words.
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 128; a += 4)
                do_op(d, "init", 2'd1, 2'd2, 1'b0, 9'(a), $urandom);

        // Big-endian loads with 2 wait states
        do_op(0, "st_8bad", 2'd1, 2'd2, 1'b0, 9'h010, 32'h8BADF00D);
        do_op(0, "ldb_010", 2'd0, 2'd0, 1'b1, 9'h010, 32'h0);
        check_val("ldb_010_const", dout[0], 32'hFFFFFF8B);
        do_op(0, "ldh_012", 2'd0, 2'd1, 1'b0, 9'h012, 32'h0);
        check_val("ldh_012_const", dout[0], 32'h0000F00D);
        do_op(0, "ldb_013", 2'd0, 2'd0, 1'b1, 9'h013, 32'h0);
        check_val("ldb_013_const", dout[0], 32'h0000000D);

        // Alignment / illegal requests
        do_op(0, "ldw_013_trap", 2'd0, 2'd2, 1'b0, 9'h013, 32'h0);
        check_val("ldw_013_keep", dout[0], 32'h0000000D);
        do_op(0, "st_004", 2'd1, 2'd2, 1'b0, 9'h004, 32'h01234567);
        do_op(0, "sth_005_trap", 2'd1, 2'd1, 1'b0, 9'h005, 32'hFFFF);
        do_op(0, "ldw_004", 2'd0, 2'd2, 1'b0, 9'h004, 32'h0);
        check_val("ldw_004_const", dout[0], 32'h01234567);
        do_op(0, "size11_trap", 2'd0, 2'd3, 1'b0, 9'h008, 32'h0);
        do_op(0, "swapb_trap", 2'd2, 2'd0, 1'b0, 9'h008, 32'h0);

        // Atomics
        do_op(0, "st_020", 2'd1, 2'd2, 1'b0, 9'h020, 32'h11223344);
        do_op(0, "swap_020", 2'd2, 2'd2, 1'b0, 9'h020, 32'hAABBCCDD);
        check_val("swap_020_const", dout[0], 32'h11223344);
        do_op(0, "ldw_020", 2'd0, 2'd2, 1'b0, 9'h020, 32'h0);
        check_val("ldw_020_const", dout[0], 32'hAABBCCDD);
        do_op(0, "stb_030", 2'd1, 2'd0, 1'b0, 9'h030, 32'h0);
        do_op(0, "ldstub1", 2'd3, 2'd0, 1'b1, 9'h030, 32'h0);
        check_val("ldstub1_const", dout[0], 32'h00000000);
        do_op(0, "ldstub2", 2'd3, 2'd0, 1'b1, 9'h030, 32'h0);
        check_val("ldstub2_const", dout[0], 32'h000000FF);

        // Req pulsed while busy must be ignored
        @(negedge clk);
        issue(0, 2'd0, 2'd2, 1'b0, 9'h008, 32'h0);
        finish_op(0, "poke", 1'b1);
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done[0]) extra = 1'b1;
        end
        check_val("poke_single_done", 32'(extra), 32'd0);
        do_op(0, "ldw_000_after_poke", 2'd0, 2'd2, 1'b0, 9'h000, 32'h0);

        // Back-to-back: second request issued in the done cycle
        @(negedge clk);
        issue(0, 2'd1, 2'd2, 1'b0, 9'h044, 32'h5EED1234);
        finish_op(0, "b2b_st", 1'b0);
        issue(0, 2'd0, 2'd2, 1'b0, 9'h044, 32'h0);
        finish_op(0, "b2b_ld", 1'b0);
        check_val("b2b_ld_const", dout[0], 32'h5EED1234);

        // Top of memory
        do_op(0, "st_1fc", 2'd1, 2'd2, 1'b0, 9'h1FC, 32'hCAFEBABE);
        do_op(0, "ldw_1fc", 2'd0, 2'd2, 1'b0, 9'h1FC, 32'h0);
        check_val("ldw_1fc_const", dout[0], 32'hCAFEBABE);
        do_op(0, "ldw_000_nowrap", 2'd0, 2'd2, 1'b0, 9'h000, 32'h0);

        // Reset mid-WAIT aborts a store
        do_op(0, "st_040_zero", 2'd1, 2'd2, 1'b0, 9'h040, 32'h0);
        @(negedge clk);
        op[0] = 2'd1; size[0] = 2'd2; se[0] = 1'b0; addr[0] = 9'h040; din[0] = 32'hDEADBEEF;
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy[0]), 32'd0);
        check_val("abort_done", 32'(done[0]), 32'd0);
        check_val("abort_trap", 32'(trap[0]), 32'd0);
        check_val("abort_dout", dout[0], 32'h0);
        exp_dout[0] = 32'h0;
        exp_dout[1] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(0, "ldw_040_after_abort", 2'd0, 2'd2, 1'b0, 9'h040, 32'h0);
        check_val("ldw_040_const", dout[0], 32'h0);

        // Zero wait states
        do_op(1, "ws0_st", 2'd1, 2'd2, 1'b0, 9'h018, 32'h600DCAFE);
        do_op(1, "ws0_ldw", 2'd0, 2'd2, 1'b0, 9'h018, 32'h0);
        check_val("ws0_ldw_const", dout[1], 32'h600DCAFE);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 100; t++) begin
                ro = 2'($urandom_range(0, 3));
                rs = (ro == 2'd2) ? 2'd2 : (ro == 2'd3) ? 2'd0 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) rs = 2'($urandom_range(0, 3));
                ra = 9'($urandom_range(0, 127));
                if ($urandom_range(0, 7) != 0 && rs != 2'd3) ra = ra & ~9'((1 << rs) - 1);
                do_op(d, "rand", ro, rs, 1'($urandom), ra, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
